// File: rtl/product_accumulator.sv
// product_accumulator
// Sums NTERMS consecutive unsigned products from the upstream multiplier.
// The finished sum is held on a valid/ready output port until it is taken.
// A two-state machine controls the block:
//   ACCUM - accept products and add them to the running sum
//   HOLD  - present the finished sum and wait for the consumer
// clear is a synchronous abort and takes priority over both handshakes.
// Parameter constraints: AW >= PW and NTERMS >= 1.

module product_accumulator #(
  parameter int PW     = 32,
  parameter int AW     = 40,
  parameter int NTERMS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PW-1:0]                product,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AW-1:0]                acc_out,
  output logic [$clog2(NTERMS+1)-1:0]  term_count,
  output logic                         overflow
);

  localparam int CW = $clog2(NTERMS + 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic [AW:0]     sum_ext_s;
  logic            accept_s;
  logic            last_term_s;
  logic            in_ready_s;

  // Handshake qualifiers: in_ready depends only on state and clear,
  // so it never forms a combinational path from in_valid or out_ready.
  always_comb begin
    in_ready_s  = (state_q == ST_ACCUM) && !clear;
    accept_s    = in_valid && in_ready_s;
    last_term_s = (count_q == CW'(NTERMS - 1));
    // One extra bit captures the carry-out of the AW-bit sum.
    sum_ext_s   = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, product};
  end

  // Next-state logic: clear first, then the state-specific handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ST_ACCUM;
      acc_d   = {AW{1'b0}};
      count_d = {CW{1'b0}};
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_s) begin
            acc_d   = sum_ext_s[AW-1:0];
            count_d = count_q + CW'(1);
            ovf_d   = ovf_q | sum_ext_s[AW];
            if (last_term_s) begin
              state_d = ST_HOLD;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_ACCUM;
            acc_d   = {AW{1'b0}};
            count_d = {CW{1'b0}};
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_ACCUM;
          acc_d   = {AW{1'b0}};
          count_d = {CW{1'b0}};
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset drops everything to an empty ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = (state_q == ST_HOLD);
  assign acc_out    = acc_q;
  assign term_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator.
// The main instance uses the default AW=40. A second instance uses AW=33, so
// random 32-bit products wrap often. Both see the same stimulus.
// The reference model keeps the true, unbounded sum of the accepted products
// and the number of terms. Expected outputs are derived from that sum:
//   acc_out  = sum mod 2^AW
//   overflow = (sum >= 2^AW)

module tb_product_accumulator;

  localparam int NT  = 4;
  localparam int AWA = 40;
  localparam int AWB = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] product = 32'd0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic            a_in_ready, a_out_valid, a_overflow;
  logic [AWA-1:0]  a_acc;
  logic [2:0]      a_cnt;
  logic            b_in_ready, b_out_valid, b_overflow;
  logic [AWB-1:0]  b_acc;
  logic [2:0]      b_cnt;

  product_accumulator #(.PW(32), .AW(AWA), .NTERMS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .product(product), .clear(clear), .out_valid(a_out_valid),
    .out_ready(out_ready), .acc_out(a_acc), .term_count(a_cnt),
    .overflow(a_overflow)
  );

  product_accumulator #(.PW(32), .AW(AWB), .NTERMS(NT)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .product(product), .clear(clear), .out_valid(b_out_valid),
    .out_ready(out_ready), .acc_out(b_acc), .term_count(b_cnt),
    .overflow(b_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: true sum of the accepted products and the term count.
  longint unsigned m_sum = 0;
  int              m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] wrap(input longint unsigned s, input int aw);
    longint unsigned m;
    m = (64'd1 << aw) - 64'd1;
    return s & m;
  endfunction

  function automatic logic ovf_of(input longint unsigned s, input int aw);
    return (s >> aw) != 64'd0;
  endfunction

  task automatic check_all(input logic rst_active);
    logic holding;
    logic exp_rdy;
    holding = (m_cnt == NT);
    exp_rdy = !rst_active ? (!holding && !clear) : !clear;
    chk("a_in_ready",  {63'd0, a_in_ready},  {63'd0, exp_rdy});
    chk("a_out_valid", {63'd0, a_out_valid}, {63'd0, holding});
    chk("a_acc_out",   {24'd0, a_acc},       wrap(m_sum, AWA));
    chk("a_term_count", {61'd0, a_cnt},      64'(m_cnt));
    chk("a_overflow",  {63'd0, a_overflow},  {63'd0, ovf_of(m_sum, AWA)});
    chk("b_in_ready",  {63'd0, b_in_ready},  {63'd0, exp_rdy});
    chk("b_out_valid", {63'd0, b_out_valid}, {63'd0, holding});
    chk("b_acc_out",   {31'd0, b_acc},       wrap(m_sum, AWB));
    chk("b_term_count", {61'd0, b_cnt},      64'(m_cnt));
    chk("b_overflow",  {63'd0, b_overflow},  {63'd0, ovf_of(m_sum, AWB)});
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // to what the next rising edge should produce.
  task automatic step(input logic v, input logic [31:0] p, input logic c, input logic r);
    logic holding;
    @(negedge clk);
    in_valid  = v;
    product   = p;
    clear     = c;
    out_ready = r;
    #1;
    check_all(1'b0);
    holding = (m_cnt == NT);
    if (c) begin
      m_sum = 0;
      m_cnt = 0;
    end else if (holding) begin
      if (r) begin
        m_sum = 0;
        m_cnt = 0;
      end
    end else if (v) begin
      m_sum = m_sum + longint'(p);
      m_cnt = m_cnt + 1;
    end
  endtask

  initial begin
    // Reset state while rst_n is low.
    #2;
    check_all(1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sum 40+64+56+10 = 170, consumer always ready.
    step(1'b1, 32'd40, 1'b0, 1'b1);
    step(1'b1, 32'd64, 1'b0, 1'b1);
    step(1'b1, 32'd56, 1'b0, 1'b1);
    step(1'b1, 32'd10, 1'b0, 1'b1);
    step(1'b0, 32'd0,  1'b0, 1'b1);
    step(1'b0, 32'd0,  1'b0, 1'b1);

    // Backpressure: the result is held for 5 cycles, then the handshake occurs.
    step(1'b1, 32'd40, 1'b0, 1'b0);
    step(1'b1, 32'd64, 1'b0, 1'b0);
    step(1'b1, 32'd56, 1'b0, 1'b0);
    step(1'b1, 32'd10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'd99, 1'b0, 1'b0);
    step(1'b1, 32'd99, 1'b0, 1'b1);
    step(1'b0, 32'd0,  1'b0, 1'b0);

    // Gaps between accepted products.
    step(1'b1, 32'd40, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd7, 1'b0, 1'b0);
    step(1'b1, 32'd64, 1'b0, 1'b0);
    step(1'b1, 32'd56, 1'b0, 1'b0);
    step(1'b1, 32'd10, 1'b0, 1'b0);
    step(1'b0, 32'd0,  1'b0, 1'b1);

    // clear together with in_valid after a partial sum of 104.
    step(1'b1, 32'd40, 1'b0, 1'b0);
    step(1'b1, 32'd64, 1'b0, 1'b0);
    step(1'b1, 32'd56, 1'b1, 1'b0);
    step(1'b1, 32'd5,  1'b0, 1'b0);
    step(1'b1, 32'd8,  1'b0, 1'b0);
    step(1'b1, 32'd7,  1'b0, 1'b0);
    step(1'b1, 32'd5,  1'b0, 1'b0);
    step(1'b0, 32'd0,  1'b1, 1'b0);
    step(1'b0, 32'd0,  1'b0, 1'b0);

    // Wrap-around: the AW=33 instance overflows, the AW=40 instance does not.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset while HOLD is active, asserted mid-cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hF000_0000, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_sum = 0;
    m_cnt = 0;
    check_all(1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic: mixed product ranges, occasional clear, random backpressure.
    for (int i = 0; i < 3000; i++) begin
      logic        v, c, r;
      logic [31:0] p;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 2))
        0:       p = $urandom_range(0, 255);
        1:       p = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: p = $urandom;
      endcase
      step(v, p, c, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
